// File: rtl/vvu_accu_axi.sv
// vvu_accu_axi: depthwise vector-vector unit on AXI-Stream ports.
// Each beat takes PE x SIMD activation/weight pairs. It forms PE dot
// products and accumulates them over SF = MW/SIMD beats. After each
// group of SF beats it emits one beat of PE narrowed results.
//
// Ports:
//   ap_clk, ap_rst_n         clock, synchronous active-low reset
//   s_axis_weights_*         [PE][SIMD] signed weights
//   s_axis_input_*           activations, interleaved or planar lanes
//   m_axis_output_*          [PE][ACCU_WIDTH] results, pad bits zero
`timescale 1ns/1ps

module vvu_accu_axi #(
    parameter int MW                 = 25,
    parameter int MH                 = 4,
    parameter int PE                 = 2,
    parameter int SIMD               = 25,
    parameter int ACTIVATION_WIDTH   = 4,
    parameter int WEIGHT_WIDTH       = 4,
    parameter int ACCU_WIDTH         = 17,
    parameter bit SIGNED_ACTIVATIONS = 1,
    parameter bit INTERLEAVED        = 1,
    parameter bit SATURATE           = 0
) (
    input  logic ap_clk,
    input  logic ap_rst_n,
    input  logic [((PE*SIMD*WEIGHT_WIDTH+7)/8)*8-1:0] s_axis_weights_tdata,
    input  logic s_axis_weights_tvalid,
    output logic s_axis_weights_tready,
    input  logic [((PE*SIMD*ACTIVATION_WIDTH+7)/8)*8-1:0] s_axis_input_tdata,
    input  logic s_axis_input_tvalid,
    output logic s_axis_input_tready,
    output logic [((PE*ACCU_WIDTH+7)/8)*8-1:0] m_axis_output_tdata,
    output logic m_axis_output_tvalid,
    input  logic m_axis_output_tready
);

    localparam int A   = ACTIVATION_WIDTH;
    localparam int W   = WEIGHT_WIDTH;
    localparam int SF  = MW / SIMD;
    localparam int PW  = A + W;
    localparam int AW  = A + W + 1 + $clog2(MW);
    localparam int XW  = (AW > ACCU_WIDTH ? AW : ACCU_WIDTH) + 1;
    localparam int CW  = (SF > 1) ? $clog2(SF) : 1;
    localparam int IW  = ((PE*SIMD*A+7)/8)*8;
    localparam int WDW = ((PE*SIMD*W+7)/8)*8;
    localparam int OW  = ((PE*ACCU_WIDTH+7)/8)*8;
    // Channel count only sets how many output beats form a pixel.
    localparam int nf_unused = MH / PE;

    localparam logic signed [XW-1:0] SMAX =
        {{(XW-ACCU_WIDTH+1){1'b0}}, {(ACCU_WIDTH-1){1'b1}}};
    localparam logic signed [XW-1:0] SMIN =
        {{(XW-ACCU_WIDTH+1){1'b1}}, {(ACCU_WIDTH-1){1'b0}}};

    logic en;
    logic fire;
    logic [CW-1:0] sf_cnt;

    logic signed [PW-1:0] prod [PE][SIMD];
    logic signed [PW-1:0] p1   [PE][SIMD];
    logic s1_valid, s1_first, s1_last;

    logic signed [AW-1:0] sum1 [PE];
    logic signed [AW-1:0] sum2 [PE];
    logic s2_valid, s2_first, s2_last;

    logic signed [AW-1:0] acc      [PE];
    logic signed [AW-1:0] acc_next [PE];
    logic signed [XW-1:0] wide     [PE];
    logic [ACCU_WIDTH-1:0] narrow  [PE];
    logic [OW-1:0] out_next;
    logic [OW-1:0] out_data;
    logic out_valid;

    // Pad bits above the packed lanes carry no data.
    if (IW > PE*SIMD*A) begin : g_ipad
        logic ipad_unused;
        assign ipad_unused = ^s_axis_input_tdata[IW-1:PE*SIMD*A];
    end
    if (WDW > PE*SIMD*W) begin : g_wpad
        logic wpad_unused;
        assign wpad_unused = ^s_axis_weights_tdata[WDW-1:PE*SIMD*W];
    end

    // Both streams are consumed together; a held output stalls all.
    assign en = !(out_valid && !m_axis_output_tready);
    assign fire = ap_rst_n && en
                  && s_axis_input_tvalid && s_axis_weights_tvalid;
    assign s_axis_input_tready   = ap_rst_n && en && s_axis_weights_tvalid;
    assign s_axis_weights_tready = ap_rst_n && en && s_axis_input_tvalid;

    assign m_axis_output_tdata  = out_data;
    assign m_axis_output_tvalid = out_valid;

    function automatic int act_lane(input int k, input int l);
        return INTERLEAVED ? (k + l*PE) : (k*SIMD + l);
    endfunction

    // Operands are widened to the product width so the multiply
    // itself cannot truncate.
    function automatic logic signed [PW-1:0] mul(
        input logic [A-1:0] a,
        input logic [W-1:0] w
    );
        logic signed [PW-1:0] ax;
        logic signed [PW-1:0] wx;
        ax = SIGNED_ACTIVATIONS ? {{(PW-A){a[A-1]}}, a}
                                : {{(PW-A){1'b0}}, a};
        wx = {{(PW-W){w[W-1]}}, w};
        return ax * wx;
    endfunction

    always_comb begin
        for (int k = 0; k < PE; k++) begin
            for (int l = 0; l < SIMD; l++) begin
                prod[k][l] = mul(
                    s_axis_input_tdata[act_lane(k, l)*A +: A],
                    s_axis_weights_tdata[(k*SIMD+l)*W +: W]);
            end
        end
    end

    always_comb begin
        for (int k = 0; k < PE; k++) begin
            sum1[k] = '0;
            for (int l = 0; l < SIMD; l++) begin
                sum1[k] = sum1[k] + AW'(p1[k][l]);
            end
        end
    end

    always_comb begin
        out_next = '0;
        for (int k = 0; k < PE; k++) begin
            acc_next[k] = s2_first ? sum2[k] : acc[k] + sum2[k];
            wide[k] = {{(XW-AW){acc_next[k][AW-1]}}, acc_next[k]};
            narrow[k] = wide[k][ACCU_WIDTH-1:0];
            if (SATURATE) begin
                if (wide[k] > SMAX) begin
                    narrow[k] = SMAX[ACCU_WIDTH-1:0];
                end else if (wide[k] < SMIN) begin
                    narrow[k] = SMIN[ACCU_WIDTH-1:0];
                end
            end
            out_next[k*ACCU_WIDTH +: ACCU_WIDTH] = narrow[k];
        end
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            sf_cnt    <= '0;
            s1_valid  <= 1'b0;
            s1_first  <= 1'b0;
            s1_last   <= 1'b0;
            s2_valid  <= 1'b0;
            s2_first  <= 1'b0;
            s2_last   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            for (int k = 0; k < PE; k++) begin
                acc[k]  <= '0;
                sum2[k] <= '0;
                for (int l = 0; l < SIMD; l++) begin
                    p1[k][l] <= '0;
                end
            end
        end else if (en) begin
            s1_valid <= fire;
            if (fire) begin
                p1       <= prod;
                s1_first <= (sf_cnt == '0);
                s1_last  <= (sf_cnt == CW'(SF-1));
                sf_cnt   <= (sf_cnt == CW'(SF-1)) ? '0 : sf_cnt + 1'b1;
            end
            s2_valid <= s1_valid;
            s2_first <= s1_first;
            s2_last  <= s1_last;
            sum2     <= sum1;
            if (s2_valid) begin
                acc <= acc_next;
            end
            // en already implies the old beat left or was never valid.
            out_valid <= s2_valid && s2_last;
            if (s2_valid && s2_last) begin
                out_data <= out_next;
            end
        end
    end

endmodule

// File: tb/tb_vvu_accu_axi.sv
// tb_vvu_accu_axi: four vvu_accu_axi variants on one shared stimulus.
// Results are checked against a dot-product reference model.
`timescale 1ns/1ps

module tb_vvu_accu_axi;

    // Per-instance configuration, bit i belongs to instance ui.
    localparam logic [3:0] SGN = 4'b0111;
    localparam logic [3:0] INT = 4'b1011;
    localparam logic [3:0] SAT = 4'b0010;

    typedef struct packed {
        logic [39:0] o0;
        logic [15:0] o1;
        logic [15:0] o2;
        logic [15:0] o3;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic iv = 1'b0;
    logic wv = 1'b0;
    logic [23:0] id = '0;
    logic [23:0] wd = '0;
    logic o_rdy = 1'b1;
    logic [3:0] in_rdy;
    logic [3:0] w_rdy;
    logic [3:0] ov;
    logic [39:0] od0;
    logic [15:0] od1, od2, od3;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_fire = 0;
    int t2 = -1;
    int first_ov = -1;
    int fold = 0;
    int part [4][2];
    logic [16:0] nv [4][2];
    exp_t exp_q [$];
    exp_t e;
    bit hold_ok = 0;
    logic [39:0] hold0;
    logic [47:0] hold123;
    logic [39:0] last_o0 = '0;
    logic [15:0] last_o1 = '0;
    logic [15:0] last_o2 = '0;
    logic [15:0] last_o3 = '0;

    always #5 clk = ~clk;

    vvu_accu_axi #(
        .MW(6), .MH(4), .PE(2), .SIMD(3),
        .ACTIVATION_WIDTH(4), .WEIGHT_WIDTH(4), .ACCU_WIDTH(17),
        .SIGNED_ACTIVATIONS(1'b1), .INTERLEAVED(1'b1), .SATURATE(1'b0)
    ) u0 (
        .ap_clk(clk), .ap_rst_n(rst_n),
        .s_axis_weights_tdata(wd), .s_axis_weights_tvalid(wv),
        .s_axis_weights_tready(w_rdy[0]),
        .s_axis_input_tdata(id), .s_axis_input_tvalid(iv),
        .s_axis_input_tready(in_rdy[0]),
        .m_axis_output_tdata(od0), .m_axis_output_tvalid(ov[0]),
        .m_axis_output_tready(o_rdy)
    );

    vvu_accu_axi #(
        .MW(6), .MH(4), .PE(2), .SIMD(3),
        .ACTIVATION_WIDTH(4), .WEIGHT_WIDTH(4), .ACCU_WIDTH(8),
        .SIGNED_ACTIVATIONS(1'b1), .INTERLEAVED(1'b1), .SATURATE(1'b1)
    ) u1 (
        .ap_clk(clk), .ap_rst_n(rst_n),
        .s_axis_weights_tdata(wd), .s_axis_weights_tvalid(wv),
        .s_axis_weights_tready(w_rdy[1]),
        .s_axis_input_tdata(id), .s_axis_input_tvalid(iv),
        .s_axis_input_tready(in_rdy[1]),
        .m_axis_output_tdata(od1), .m_axis_output_tvalid(ov[1]),
        .m_axis_output_tready(o_rdy)
    );

    vvu_accu_axi #(
        .MW(6), .MH(4), .PE(2), .SIMD(3),
        .ACTIVATION_WIDTH(4), .WEIGHT_WIDTH(4), .ACCU_WIDTH(8),
        .SIGNED_ACTIVATIONS(1'b1), .INTERLEAVED(1'b0), .SATURATE(1'b0)
    ) u2 (
        .ap_clk(clk), .ap_rst_n(rst_n),
        .s_axis_weights_tdata(wd), .s_axis_weights_tvalid(wv),
        .s_axis_weights_tready(w_rdy[2]),
        .s_axis_input_tdata(id), .s_axis_input_tvalid(iv),
        .s_axis_input_tready(in_rdy[2]),
        .m_axis_output_tdata(od2), .m_axis_output_tvalid(ov[2]),
        .m_axis_output_tready(o_rdy)
    );

    vvu_accu_axi #(
        .MW(6), .MH(4), .PE(2), .SIMD(3),
        .ACTIVATION_WIDTH(4), .WEIGHT_WIDTH(4), .ACCU_WIDTH(8),
        .SIGNED_ACTIVATIONS(1'b0), .INTERLEAVED(1'b1), .SATURATE(1'b0)
    ) u3 (
        .ap_clk(clk), .ap_rst_n(rst_n),
        .s_axis_weights_tdata(wd), .s_axis_weights_tvalid(wv),
        .s_axis_weights_tready(w_rdy[3]),
        .s_axis_input_tdata(id), .s_axis_input_tvalid(iv),
        .s_axis_input_tready(in_rdy[3]),
        .m_axis_output_tdata(od3), .m_axis_output_tvalid(ov[3]),
        .m_axis_output_tready(o_rdy)
    );

    task automatic check(
        input string tag,
        input logic [63:0] got,
        input logic [63:0] want
    );
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    // Dot product of channel k over one beat, from the lane rules.
    function automatic int dot(
        input logic [23:0] a,
        input logic [23:0] w,
        input int k,
        input bit sgn,
        input bit inter
    );
        int s;
        int lane;
        logic [3:0] ab;
        logic [3:0] wb;
        s = 0;
        for (int l = 0; l < 3; l++) begin
            lane = inter ? (k + l*2) : (k*3 + l);
            ab = a[lane*4 +: 4];
            wb = w[(k*3+l)*4 +: 4];
            s += (sgn ? int'($signed(ab)) : int'(ab)) * int'($signed(wb));
        end
        return s;
    endfunction

    function automatic logic [16:0] nar(input int v, input int bits,
                                        input bit sat);
        int lo;
        int hi;
        lo = -(1 << (bits-1));
        hi = (1 << (bits-1)) - 1;
        if (sat && v > hi) v = hi;
        if (sat && v < lo) v = lo;
        return 17'(v & ((1 << bits) - 1));
    endfunction

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!rst_n) begin
            fold = 0;
            n_fire = 0;
            t2 = -1;
            first_ov = -1;
            hold_ok = 0;
            exp_q.delete();
            for (int i = 0; i < 4; i++) begin
                part[i][0] = 0;
                part[i][1] = 0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                check("in_rdy_rule", in_rdy[i],
                      !(ov[i] && !o_rdy) && wv);
                check("w_rdy_rule", w_rdy[i],
                      !(ov[i] && !o_rdy) && iv);
            end
            if (first_ov < 0 && ov[0]) first_ov = cyc;
            if (ov[0] && !o_rdy) begin
                if (hold_ok) begin
                    check("hold0", od0, hold0);
                    check("hold123", {od1, od2, od3}, hold123);
                end
                hold0 = od0;
                hold123 = {od1, od2, od3};
                hold_ok = 1;
            end else begin
                hold_ok = 0;
            end
            if (ov[0] && o_rdy) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("valid123", ov[3:1], 3'b111);
                    check("out_u0", od0, e.o0);
                    check("out_u1", od1, e.o1);
                    check("out_u2", od2, e.o2);
                    check("out_u3", od3, e.o3);
                end
                last_o0 = od0;
                last_o1 = od1;
                last_o2 = od2;
                last_o3 = od3;
            end
            if (iv && wv && in_rdy[0]) begin
                n_fire++;
                if (n_fire == 2) t2 = cyc;
                for (int i = 0; i < 4; i++) begin
                    for (int k = 0; k < 2; k++) begin
                        part[i][k] = (fold == 0 ? 0 : part[i][k])
                                     + dot(id, wd, k, SGN[i], INT[i]);
                        nv[i][k] = nar(part[i][k], (i == 0) ? 17 : 8,
                                       SAT[i]);
                    end
                end
                if (fold == 1) begin
                    e.o0 = {6'b0, nv[0][1], nv[0][0]};
                    e.o1 = {nv[1][1][7:0], nv[1][0][7:0]};
                    e.o2 = {nv[2][1][7:0], nv[2][0][7:0]};
                    e.o3 = {nv[3][1][7:0], nv[3][0][7:0]};
                    exp_q.push_back(e);
                end
                fold = (fold + 1) % 2;
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        iv = 1'b1;
        wv = 1'b1;
        id = '1;
        wd = '1;
        o_rdy = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_rdy", in_rdy, 4'b0);
        check("rst_w_rdy", w_rdy, 4'b0);
        check("rst_valid", ov, 4'b0);
        check("rst_data", {od0, od1}, 56'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        iv = 1'b0;
        wv = 1'b0;
    endtask

    task automatic run(input int n, input logic [23:0] ca,
                       input logic [23:0] cw, input bit rnd);
        int sent;
        int guard;
        int stall;
        sent = 0;
        guard = 0;
        stall = 10;
        @(posedge clk);
        #1;
        while (sent < n && guard < 2000) begin
            iv = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            wv = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            id = rnd ? 24'($urandom) : ca;
            wd = rnd ? 24'($urandom) : cw;
            if (rnd && sent >= 4 && stall > 0) begin
                o_rdy = 1'b0;
                stall--;
            end else begin
                o_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            @(negedge clk);
            if (iv && wv && in_rdy[0]) sent++;
            @(posedge clk);
            #1;
            guard++;
        end
        iv = 1'b0;
        wv = 1'b0;
        o_rdy = 1'b1;
        check("run_sent", sent, n);
    endtask

    task automatic drain();
        int g;
        g = 0;
        o_rdy = 1'b1;
        while ((exp_q.size() != 0 || ov[0]) && g < 100) begin
            @(negedge clk);
            g++;
        end
        #1;
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        do_reset();

        run(4, 24'h111111, 24'h111111, 1'b0);
        drain();
        check("latency", first_ov - t2, 3);
        check("ones_u0", last_o0, {6'b0, 17'd6, 17'd6});

        run(2, 24'h888888, 24'h888888, 1'b0);
        drain();
        check("sat_u1", last_o1, 16'h7f7f);
        check("wrap_u2", last_o2, 16'h8080);

        run(2, 24'hffffff, 24'hffffff, 1'b0);
        drain();
        check("unsigned_u3", last_o3, 16'ha6a6);

        run(2, 24'h654321, 24'h111111, 1'b0);
        drain();
        check("inter_u0", last_o0, {6'b0, 17'd24, 17'd18});
        check("planar_u2", last_o2, {8'd30, 8'd12});

        run(40, 24'h0, 24'h0, 1'b1);
        drain();

        run(1, 24'h777777, 24'h777777, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        run(2, 24'h111111, 24'h111111, 1'b0);
        drain();
        check("rst_mid_u0", last_o0, {6'b0, 17'd6, 17'd6});

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
